mdl_xxx_bram_dump_sched: RTL

Round-robin scheduler that shares the single BRAM-to-AXI-stream dump engine among up to PRM_NREQ requesters (sign, NTT, sampler units). It grants one requester at a time and selects that requester's polynomial bank. It issues the one-cycle start pulse to the dump engine, counts the beats that are actually transferred, generates TLAST on the final beat, and returns a per-requester done pulse. A watchdog and beat-overflow check report engine or stream faults.

---
 rtl/mdl_xxx_bram_dump_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mdl_xxx_bram_dump_sched.sv
// Round-robin owner of the shared BRAM dump engine: grants one requester, pulses start,
// counts stream beats, drives TLAST on the final beat and reports watchdog/overflow faults.
module mdl_xxx_bram_dump_sched #(
   parameter int PRM_NREQ   = 4,
   parameter int PRM_SELW   = 2,
   parameter int PRM_COEFFS = 4096,
   parameter int PRM_WDOG   = 1024
) (
   input  logic                iSYS_CLK,
   input  logic                iSYS_RST,
   input  logic [PRM_NREQ-1:0] iREQ,
   output logic [PRM_NREQ-1:0] oGNT,
   output logic [PRM_NREQ-1:0] oDONE,
   output logic [PRM_SELW-1:0] oSEL,
   output logic                oBUSY,
   output logic                oENG_START,
   input  logic                iENG_DONE,
   input  logic                iWm_Tvalid,
   input  logic                iWm_Tready,
   output logic                oWm_Tlast,
   output logic                oERR,
   output logic [1:0]          oERR_CODE,
   input  logic                iERR_CLR
);

   localparam int BEATS = PRM_COEFFS / 2;
   localparam int CNTW  = $clog2(BEATS) + 1;
   localparam int STLW  = (PRM_WDOG > 1) ? $clog2(PRM_WDOG + 1) : 1;
   localparam logic [CNTW-1:0] BEATS_C  = CNTW'(BEATS);
   localparam logic [CNTW-1:0] BEATS_M1 = CNTW'(BEATS - 1);
   localparam logic [STLW-1:0] WDOG_C   = STLW'(PRM_WDOG);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_DONE} state_t;

   state_t              state, state_nxt;
   logic [CNTW-1:0]     beat_cnt, beat_cnt_nxt;
   logic [STLW-1:0]     stall_cnt, stall_cnt_nxt;
   logic                eng_done_seen, eng_done_seen_nxt;
   logic [PRM_SELW-1:0] ptr, win_idx;
   logic                win_vld;
   logic                in_run, beat, wdog_hit, ovf_hit;
   logic [1:0]          err_code_nxt;
   int                  best_off;

   assign in_run    = (state == ST_RUN);
   assign beat      = in_run & iWm_Tvalid & iWm_Tready;
   assign oBUSY     = (state != ST_IDLE);
   assign oWm_Tlast = in_run & iWm_Tvalid & (beat_cnt == BEATS_M1);

   // winner is the requester with the smallest cyclic distance from ptr
   always_comb begin
      best_off = PRM_NREQ;
      win_idx  = '0;
      win_vld  = |iREQ;
      for (int j = 0; j < PRM_NREQ; j++) begin
         if (iREQ[j] && (((j - int'(ptr) + PRM_NREQ) % PRM_NREQ) < best_off)) begin
            best_off = (j - int'(ptr) + PRM_NREQ) % PRM_NREQ;
            win_idx  = PRM_SELW'(j);
         end
      end
   end

   always_comb begin
      state_nxt         = state;
      beat_cnt_nxt      = beat_cnt;
      stall_cnt_nxt     = stall_cnt;
      eng_done_seen_nxt = eng_done_seen;
      wdog_hit          = 1'b0;
      ovf_hit           = 1'b0;
      case (state)
         ST_IDLE: begin
            if (win_vld) state_nxt = ST_START;
         end
         ST_START: begin
            beat_cnt_nxt      = '0;
            stall_cnt_nxt     = '0;
            eng_done_seen_nxt = 1'b0;
            state_nxt         = ST_RUN;
         end
         ST_RUN: begin
            eng_done_seen_nxt = eng_done_seen | iENG_DONE;
            if (beat) begin
               stall_cnt_nxt = '0;
               // a beat past the job length is flagged but never counted
               if (beat_cnt == BEATS_C) ovf_hit = 1'b1;
               else                     beat_cnt_nxt = beat_cnt + 1'b1;
            end else if (stall_cnt != '1) begin
               stall_cnt_nxt = stall_cnt + 1'b1;
            end
            if ((beat_cnt_nxt == BEATS_C) && eng_done_seen_nxt) begin
               state_nxt = ST_DONE;
            end else if ((PRM_WDOG != 0) && !beat && (stall_cnt_nxt == WDOG_C)) begin
               wdog_hit  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // a fault raised in the same cycle as a clear survives it
   assign err_code_nxt = (iERR_CLR ? 2'b00 : oERR_CODE) | {ovf_hit, wdog_hit};

   always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
      if (iSYS_RST) begin
         state         <= ST_IDLE;
         beat_cnt      <= '0;
         stall_cnt     <= '0;
         eng_done_seen <= 1'b0;
         ptr           <= '0;
         oGNT          <= '0;
         oDONE         <= '0;
         oSEL          <= '0;
         oENG_START    <= 1'b0;
         oERR          <= 1'b0;
         oERR_CODE     <= 2'b00;
      end else begin
         state         <= state_nxt;
         beat_cnt      <= beat_cnt_nxt;
         stall_cnt     <= stall_cnt_nxt;
         eng_done_seen <= eng_done_seen_nxt;
         oERR_CODE     <= err_code_nxt;
         oERR          <= |err_code_nxt;
         oENG_START    <= (state == ST_IDLE) & win_vld;
         oDONE         <= '0;
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  oGNT <= PRM_NREQ'(1) << win_idx;
                  oSEL <= win_idx;
               end
            end
            ST_RUN: begin
               if (state_nxt == ST_DONE) oDONE <= oGNT;
            end
            ST_DONE: begin
               oGNT <= '0;
               ptr  <= (oSEL == PRM_SELW'(PRM_NREQ - 1)) ? '0 : oSEL + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
